// File: rtl/fifo_sync.sv
// -----------------------------------------------------------------------------
// fifo_sync
//
// Parametrised synchronous FIFO with show-ahead read data, a fill-level output,
// almost-full/almost-empty flags and true simultaneous push/pop. When full,
// a push that comes with a pop reuses the slot the pop frees. When empty, a
// push that comes with a pop is accepted and the pop is ignored.
//
// Optional feature macro: FIFO_ERR_EN
//   defined   - o_overflow/o_underflow are sticky error flags, cleared by
//               i_clr_err (an error event in the same cycle wins).
//   undefined - no error registers; both flags are tied to 0 and i_clr_err
//               is ignored.
//
// Parameters:
//   DW     data width in bits
//   DEPTH  log2 of entry count, capacity N = 2**DEPTH
//   AFULL  o_afull threshold  (AEMPTY < AFULL <= N)
//   AEMPTY o_aempty threshold (0 <= AEMPTY < AFULL)
//
// Ports:
//   i_clk        clock, all state changes on the rising edge
//   i_reset      synchronous, active-high reset
//   i_dat        write data
//   i_push       write request
//   i_pop        read request (consumes the head word)
//   i_clr_err    clears the sticky error flags
//   o_dat        head word, valid whenever o_empty = 0
//   o_empty      level == 0
//   o_full       level == N
//   o_level      number of stored words, 0..N
//   o_afull      level >= AFULL
//   o_aempty     level <= AEMPTY
//   o_overflow   sticky: a push was dropped
//   o_underflow  sticky: a pop was ignored
// -----------------------------------------------------------------------------
module fifo_sync #(
  parameter int DW     = 8,
  parameter int DEPTH  = 4,
  parameter int AFULL  = 12,
  parameter int AEMPTY = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [DW-1:0]    i_dat,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clr_err,
  output logic [DW-1:0]    o_dat,
  output logic             o_empty,
  output logic             o_full,
  output logic [DEPTH:0]   o_level,
  output logic             o_afull,
  output logic             o_aempty,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int             N        = 2 ** DEPTH;
  localparam logic [DEPTH:0] N_L      = (DEPTH+1)'(N);
  localparam logic [DEPTH:0] AFULL_L  = (DEPTH+1)'(AFULL);
  localparam logic [DEPTH:0] AEMPTY_L = (DEPTH+1)'(AEMPTY);
  localparam logic [DEPTH:0] ONE_L    = (DEPTH+1)'(1);

  logic [DW-1:0]    mem_q [N];
  logic [DEPTH-1:0] rd_idx_q, rd_idx_d;
  logic [DEPTH-1:0] wr_idx_q, wr_idx_d;
  logic [DEPTH:0]   level_q, level_d;
  logic             push_ok, pop_ok;

  // A push into a full FIFO is only accepted when a pop frees a slot in
  // the same cycle; a pop from an empty FIFO is never accepted.
  assign pop_ok  = i_pop && (level_q != '0);
  assign push_ok = i_push && ((level_q != N_L) || i_pop);

  // NOTE: every variable assigned in an always_comb gets a default first,
  //       so no path through the block can leave it unassigned (no latch).
  always_comb begin
    rd_idx_d = rd_idx_q;
    wr_idx_d = wr_idx_q;
    level_d  = level_q;
    if (push_ok) wr_idx_d = wr_idx_q + 1'b1;  // wraps N-1 -> 0 naturally
    if (pop_ok)  rd_idx_d = rd_idx_q + 1'b1;
    if (push_ok && !pop_ok)      level_d = level_q + ONE_L;
    else if (pop_ok && !push_ok) level_d = level_q - ONE_L;
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  //       registers sample their next values from the same pre-edge state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      level_q  <= '0;
    end else begin
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array has no reset; contents are only meaningful
  //       between rd_idx and wr_idx, which reset does clear.
  always_ff @(posedge i_clk) begin
    if (!i_reset && push_ok) mem_q[wr_idx_q] <= i_dat;
  end

  assign o_dat    = mem_q[rd_idx_q];
  assign o_level  = level_q;
  assign o_empty  = (level_q == '0);
  assign o_full   = (level_q == N_L);
  assign o_afull  = (level_q >= AFULL_L);
  assign o_aempty = (level_q <= AEMPTY_L);

`ifdef FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // An error event in the same cycle as i_clr_err keeps the flag set.
  always_comb begin
    ovf_d = (ovf_q && !i_clr_err) || (i_push && !push_ok);
    udf_d = (udf_q && !i_clr_err) || (i_pop && !pop_ok);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign o_overflow  = ovf_q;
  assign o_underflow = udf_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = i_clr_err;
  assign o_overflow     = 1'b0;
  assign o_underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync
//
// Scoreboard bench for fifo_sync with default parameters (DW=8, N=16,
// AFULL=12, AEMPTY=2). Accepted pushes go into a queue; each accepted pop
// compares the show-ahead o_dat against the queue head. Status outputs are
// compared after every edge against the queue occupancy and a small model
// of the sticky error flags. Honours FIFO_ERR_EN the same way as the RTL.
// -----------------------------------------------------------------------------
module tb_fifo_sync;

  localparam int N = 16;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_dat = '0;
  logic       i_push = 1'b0;
  logic       i_pop = 1'b0;
  logic       i_clr_err = 1'b0;
  logic [7:0] o_dat;
  logic       o_empty, o_full, o_afull, o_aempty, o_overflow, o_underflow;
  logic [4:0] o_level;

  int checks = 0;
  int failures = 0;

  logic [7:0] sb[$];
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;

  always #5 i_clk = ~i_clk;

  fifo_sync dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_dat      (i_dat),
    .i_push     (i_push),
    .i_pop      (i_pop),
    .i_clr_err  (i_clr_err),
    .o_dat      (o_dat),
    .o_empty    (o_empty),
    .o_full     (o_full),
    .o_level    (o_level),
    .o_afull    (o_afull),
    .o_aempty   (o_aempty),
    .o_overflow (o_overflow),
    .o_underflow(o_underflow)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_status();
    int lvl;
    lvl = sb.size();
    check("level",     32'(o_level),     32'(lvl));
    check("empty",     32'(o_empty),     32'(lvl == 0));
    check("full",      32'(o_full),      32'(lvl == N));
    check("afull",     32'(o_afull),     32'(lvl >= 12));
    check("aempty",    32'(o_aempty),    32'(lvl <= 2));
    check("overflow",  32'(o_overflow),  32'(m_ovf));
    check("underflow", 32'(o_underflow), 32'(m_udf));
  endtask

  // One clock cycle of stimulus. Read data is compared before the edge,
  // since o_dat shows the head word that the pop consumes.
  task automatic step(input bit push, input bit pop, input logic [7:0] dat, input bit clr = 1'b0);
    bit push_acc, pop_acc;
    @(negedge i_clk);
    i_push = push; i_pop = pop; i_dat = dat; i_clr_err = clr;
    pop_acc  = pop && (sb.size() > 0);
    push_acc = push && ((sb.size() < N) || pop);
    if (pop_acc) begin
      check("rd_data", 32'(o_dat), 32'(sb[0]));
      void'(sb.pop_front());
    end
    if (push_acc) sb.push_back(dat);
`ifdef FIFO_ERR_EN
    m_ovf = (m_ovf && !clr) || (push && !push_acc);
    m_udf = (m_udf && !clr) || (pop && !pop_acc);
`endif
    @(posedge i_clk);
    #1;
    i_push = 1'b0; i_pop = 1'b0; i_clr_err = 1'b0;
    check_status();
  endtask

  task automatic reset_with_traffic();
    @(negedge i_clk);
    i_reset = 1'b1; i_push = 1'b1; i_pop = 1'b1; i_dat = 8'hEE;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0; i_push = 1'b0; i_pop = 1'b0;
    sb.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_status();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    check_status();
    check("rst_level_const", 32'(o_level), 32'd0);

    // Three pushes, three pops, head visible one edge after first push
    step(1, 0, 8'h11);
    check("head_after_push", 32'(o_dat), 32'h11);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    check("level_three", 32'(o_level), 32'd3);
    repeat (3) step(0, 1, 8'h00);
    check("empty_at_end", 32'(o_empty), 32'd1);

    // Fill to 16, dropped push, error flag stays set across a same-cycle clear
    for (int i = 0; i < N; i++) step(1, 0, 8'(8'hA0 + i));
    check("full_at_16", 32'(o_full), 32'd1);
    step(1, 0, 8'hAA);
    check("level_after_drop", 32'(o_level), 32'd16);
    step(1, 0, 8'hBB, 1'b1);
    for (int i = 0; i < N; i++) step(0, 1, 8'h00);
    step(0, 0, 8'h00, 1'b1);

    // Full FIFO with simultaneous push/pop: 0x55 comes out last
    for (int i = 0; i < N; i++) step(1, 0, 8'(8'hC0 + i));
    step(1, 1, 8'h55);
    check("level_full_pushpop", 32'(o_level), 32'd16);
    for (int i = 0; i < N; i++) step(0, 1, 8'h00);

    // Empty FIFO with simultaneous push/pop: push wins, underflow recorded
    step(1, 1, 8'h77);
    check("head_empty_pushpop", 32'(o_dat), 32'h77);
    check("level_empty_pushpop", 32'(o_level), 32'd1);
    step(0, 0, 8'h00, 1'b1);
    check("underflow_cleared", 32'(o_underflow), 32'd0);
    step(0, 1, 8'h00);

    // Streaming at level 3 across several index wraps
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h30 + i));
    for (int i = 0; i < 40; i++) step(1, 1, 8'(8'h40 + i));
    check("stream_level", 32'(o_level), 32'd3);
    repeat (3) step(0, 1, 8'h00);

    // Reset at level 9 with push/pop asserted, with an error flag set first
    step(0, 1, 8'h00);
    for (int i = 0; i < 9; i++) step(1, 0, 8'(8'h90 + i));
    reset_with_traffic();
    check("level_after_reset", 32'(o_level), 32'd0);
    step(1, 0, 8'h5A);
    check("head_after_reset", 32'(o_dat), 32'h5A);
    step(0, 1, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
